// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types and constants for the SRAM bus controller and its loader.
package sram_bus_ctrl_pkg;

  // CPU transaction FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StAck  = 2'd2
  } state_e;

  localparam int unsigned LANES              = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 11;
  // Bits of a byte address that select the lane within a 32-bit word
  localparam int unsigned LANE_SEL_W         = 2;

  // Byte offset within a word -> one-hot lane; lane i holds bits [8i+7:8i] (little-endian)
  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_SEL_W-1:0] byte_off);
    logic [LANES-1:0] lanes;
    lanes           = '0;
    lanes[byte_off] = 1'b1;
    return lanes;
  endfunction

endpackage

// File: rtl/sram_loader.sv
// Byte-stream loader: fills the RAM sequentially from byte address 0 while ld_en is high.
module sram_loader
  import sram_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      idle,
  input  logic                      ld_en,
  input  logic                      ld_valid,
  input  logic [7:0]                ld_data,
  output logic                      ld_ready,
  output logic [ADDR_WIDTH+2:0]     ld_count,
  output logic                      ld_overflow,
  output logic                      wr_req,
  output logic [ADDR_WIDTH-1:0]     wr_ad,
  output logic [LANES-1:0]          wr_wre,
  output logic [8*LANES-1:0]        wr_din
);

  localparam int unsigned CW = ADDR_WIDTH + 3;
  // Byte capacity of the whole RAM: 4 * 2^ADDR_WIDTH
  localparam logic [CW-1:0] FULL = {1'b1, {(ADDR_WIDTH + 2){1'b0}}};

  logic          en_q;
  logic          rise;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] eff_count;
  logic          ovf_q, ovf_d;
  logic          full;

  assign rise = ld_en & ~en_q;
  // The clear on a rising edge applies to this cycle's write, so a byte offered
  // together with the edge lands at address 0 rather than at the stale count.
  assign eff_count = rise ? '0 : count_q;
  assign full      = (eff_count == FULL);

  assign ld_ready = ~reset & ld_en & idle & ~full;
  assign wr_req   = ld_valid & ld_ready;
  assign wr_ad    = eff_count[ADDR_WIDTH+1:2];
  assign wr_wre   = lane_onehot(eff_count[1:0]);
  assign wr_din   = {LANES{ld_data}};

  assign ld_count    = count_q;
  assign ld_overflow = ovf_q;

  // Next count saturates at FULL; overflow is sticky until the next ld_en rising edge
  always_comb begin
    count_d = eff_count + CW'(wr_req);
    ovf_d   = (rise ? 1'b0 : ovf_q) | (ld_en & ld_valid & full);
  end

  // Loader state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      en_q    <= ld_en;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// picorv32 native-bus front end for four 8-bit Gowin_SP lanes, with a boot-time byte loader.
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic                  ld_en,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH+2:0] ld_count,
  output logic                  ld_overflow,
  output logic                  ram_ce,
  output logic                  ram_oce,
  output logic [3:0]            ram_wre,
  output logic [ADDR_WIDTH-1:0] ram_ad,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  state_e                state_q, state_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  cpu_accept;
  logic                  ld_wr_req;
  logic [ADDR_WIDTH-1:0] ld_wr_ad;
  logic [LANES-1:0]      ld_wr_wre;
  logic [8*LANES-1:0]    ld_wr_din;
  logic                  unused_addr_bits;

  // Only the word index within the RAM is decoded; higher bits alias
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  assign cpu_accept = mem_valid & sel & ~ld_en;
  assign ram_oce    = 1'b1;
  assign mem_rdata  = rdata_q;
  assign mem_ready  = (state_q == StAck) & ~reset;

  sram_loader #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_loader (
    .clk         (clk),
    .reset       (reset),
    .idle        (state_q == StIdle),
    .ld_en       (ld_en),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_count    (ld_count),
    .ld_overflow (ld_overflow),
    .wr_req      (ld_wr_req),
    .wr_ad       (ld_wr_ad),
    .wr_wre      (ld_wr_wre),
    .wr_din      (ld_wr_din)
  );

  // Next-state, read capture and RAM strobe mux (CPU in IDLE, else loader in IDLE)
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    ram_ce  = 1'b0;
    ram_wre = '0;
    ram_ad  = mem_addr[ADDR_WIDTH+1:2];
    ram_din = mem_wdata;
    unique case (state_q)
      StIdle: begin
        if (cpu_accept) begin
          ram_ce = 1'b1;
          if (mem_wstrb == 4'b0000) begin
            state_d = StRd;
          end else begin
            ram_wre = mem_wstrb;
            state_d = StAck;
          end
        end else if (ld_wr_req) begin
          ram_ce  = 1'b1;
          ram_ad  = ld_wr_ad;
          ram_wre = ld_wr_wre;
          ram_din = ld_wr_din;
        end
      end
      StRd: begin
        // Bypass-mode RAM: dout is valid the cycle after the address
        rdata_d = ram_dout;
        state_d = StAck;
      end
      StAck: begin
        // mem_valid is still high here; it must not start a second transaction
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      ram_ce  = 1'b0;
      ram_wre = '0;
    end
  end

  // FSM and read data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
